// File: rtl/ifq_pkg.sv
// Shared constants for the instruction fetch queue: default depth, instruction
// width, the word driven on instr_data when nothing is valid, and counter sizing.
package ifq_pkg;

    localparam int IFQ_DEPTH_DEFAULT = 4;
    localparam int INSTR_W           = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Occupancy counters need one extra bit so that "full" (== DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with synchronous clear; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only honoured when a pop frees the slot this cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(i_push && !i_clear && o_full && !i_pop));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues PC reads to instruction memory under a credit limit, tags
// returned words with their PC and hands them to decode; flush drops everything
// queued or in flight. Define IFQ_BYPASS_EN for a same-cycle response bypass.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               flush,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [AW-1:0]      instr_pc
);

    localparam int CW = cnt_w(DEPTH);
    localparam int DW = INSTR_W + AW;

    logic [CW-1:0] w_addr_count;
    logic [CW-1:0] w_data_count;
    logic [AW-1:0] w_addr_head;
    logic [DW-1:0] w_data_head;
    logic          w_addr_full;
    logic          w_addr_empty;
    logic          w_data_full;
    logic          w_data_empty;
    logic          w_credit_ok;
    logic          w_fire;
    logic          w_rsp_keep;
    logic          w_bypass;
    logic          w_data_push;
    logic          w_data_pop;
    logic [CW-1:0] w_inflight_next;
    logic [CW-1:0] r_drop_cnt;

    // Outstanding reads (including ones that will be dropped) plus buffered words
    // never exceed DEPTH, so every response is guaranteed a data FIFO slot.
    assign w_credit_ok = ({1'b0, w_addr_count} + {1'b0, w_data_count}) < (CW+1)'(DEPTH);

    assign imem_req_valid = reset & pc_valid & w_credit_ok & ~flush;
    assign pc_ready       = reset & imem_req_ready & w_credit_ok & ~flush;
    assign imem_addr      = pc_in;
    assign w_fire         = pc_valid & pc_ready;

    assign w_rsp_keep = imem_rsp_valid & (r_drop_cnt == '0) & ~flush;

`ifdef IFQ_BYPASS_EN
    assign w_bypass    = reset & w_rsp_keep & w_data_empty;
    assign w_data_push = w_rsp_keep & ~(w_bypass & instr_ready);
`else
    assign w_bypass    = 1'b0;
    assign w_data_push = w_rsp_keep;
`endif

    // A handshake in the flush cycle is ignored; the clear discards that word.
    assign w_data_pop = ~w_data_empty & instr_ready & ~flush;

    assign instr_valid = ~w_data_empty | w_bypass;

    always_comb begin
        instr_data = NOP_WORD;
        instr_pc   = '0;
        if (w_bypass) begin
            instr_data = imem_rsp_data;
            instr_pc   = w_addr_head;
        end else if (!w_data_empty) begin
            instr_data = w_data_head[DW-1:AW];
            instr_pc   = w_data_head[AW-1:0];
        end
    end

    // Reads still pending after this edge; a response landing in the flush cycle is not counted.
    assign w_inflight_next = w_addr_count + CW'(w_fire) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= w_inflight_next;
        end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    ifq_fifo #(
        .WIDTH (AW),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fire),
        .i_pop   (imem_rsp_valid),
        .i_clear (1'b0),
        .i_data  (pc_in),
        .o_data  (w_addr_head),
        .o_count (w_addr_count),
        .o_full  (w_addr_full),
        .o_empty (w_addr_empty)
    );

    ifq_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_data_push),
        .i_pop   (w_data_pop),
        .i_clear (flush),
        .i_data  ({imem_rsp_data, w_addr_head}),
        .o_data  (w_data_head),
        .o_count (w_data_count),
        .o_full  (w_data_full),
        .o_empty (w_data_empty)
    );

    a_addr_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_fire && w_addr_full));
    a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && w_addr_empty));
    a_data_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_data_push && !flush && w_data_full && !w_data_pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order memory model with variable latency,
// expected-queue scoreboard on the decode handshake, directed scenario tasks.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IFQ_BYPASS_EN
    localparam int LAT_OFF = 1;
`else
    localparam int LAT_OFF = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          flush;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] exp_q[$];
    int          mem_lat  = 1;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory model + scoreboard ----------------
    initial begin : env
        logic        s_rst, s_fire, s_rsp, s_flush, s_hs;
        logic [31:0] s_pc, s_maddr;
        logic [63:0] exp_item;
        int          due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            s_rst   = reset;
            s_fire  = pc_valid && pc_ready;
            s_pc    = pc_in;
            s_maddr = imem_addr;
            s_rsp   = imem_rsp_valid;
            s_flush = flush;
            s_hs    = instr_valid && instr_ready;
            if (!s_rst || s_flush) begin
                exp_q.delete();
            end else if (s_hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc=%h data=%h, required no instruction", instr_pc, instr_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({instr_pc, instr_data} !== exp_item) begin
                        n_fail++;
                        $display("FAIL sb_instr: got pc=%h data=%h, required pc=%h data=%h",
                                 instr_pc, instr_data, exp_item[63:32], exp_item[31:0]);
                    end
                end
            end
            if (s_rst && s_fire) exp_q.push_back({s_pc, mem_word(s_pc)});
            @(posedge clk);
            #1;
            cyc++;
            if (!s_rst) begin
                mq.delete();
            end else begin
                if (s_rsp && mq.size() > 0) void'(mq.pop_front());
                if (s_fire) begin
                    due = cyc - 1 + mem_lat;
                    if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
                    mq.push_back('{addr: s_maddr, due: due});
                end
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain();
        bit done = 1'b0;
        tick();
        pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
        for (int k = 0; k < 80 && !done; k++) begin
            @(posedge clk);
            #3;
            if (mq.size() == 0 && exp_q.size() == 0 && !instr_valid && !imem_rsp_valid) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: mem pending=%0d expected pending=%0d, required 0 and 0", mq.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_valid = 1'b1; pc_in = 32'h123; imem_req_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_instr_valid: got %b required 0", instr_valid); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
        n_checks++; if (pc_ready !== 1'b0)       begin n_fail++; $display("FAIL rst_pc_ready: got %b required 0", pc_ready); end
        n_checks++; if (instr_data !== 32'h0)    begin n_fail++; $display("FAIL rst_instr_data: got %h required 0", instr_data); end
        n_checks++; if (instr_pc !== 32'h0)      begin n_fail++; $display("FAIL rst_instr_pc: got %h required 0", instr_pc); end
        tick();
        reset = 1'b1; pc_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0)    begin n_fail++; $display("FAIL rel_instr_valid: got %b required 0", instr_valid); end
        n_checks++; if (pc_ready !== 1'b1)       begin n_fail++; $display("FAIL rel_pc_ready: got %b required 1", pc_ready); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rel_req_valid: got %b required 0", imem_req_valid); end
    endtask

    task automatic test_back_to_back();
        bit          exp_v;
        logic [31:0] exp_pc;
        drain();
        mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            pc_valid = (i < 3);
            pc_in    = 32'(4 * i);
            @(negedge clk);
            if (i < 3) begin
                n_checks++;
                if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_ready[%0d]: got %b required 1", i, pc_ready); end
            end
            exp_v  = (i >= LAT_OFF) && (i < LAT_OFF + 3);
            exp_pc = 32'(4 * (i - LAT_OFF));
            n_checks++;
            if (instr_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b required %b", i, instr_valid, exp_v); end
            if (exp_v) begin
                n_checks++;
                if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h required %h", i, instr_pc, exp_pc); end
            end
        end
    endtask

    task automatic test_full();
        int fired = 0;
        drain();
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            instr_ready = 1'b0;
            pc_valid    = 1'b1;
            pc_in       = 32'h1000 + 32'(4 * fired);
            @(negedge clk);
            if (pc_valid && pc_ready) fired++;
        end
        n_checks++; if (fired != DEPTH)    begin n_fail++; $display("FAIL full_fetch_count: got %0d required %0d", fired, DEPTH); end
        n_checks++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL full_pc_ready: got %b required 0", pc_ready); end
        tick();
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid: got %b required 1", instr_valid); end
        n_checks++; if (pc_ready !== 1'b0)    begin n_fail++; $display("FAIL full_pop_cycle_ready: got %b required 0", pc_ready); end
        tick();
        pc_in = 32'h1000 + 32'(4 * fired);
        @(negedge clk);
        n_checks++; if (pc_ready !== 1'b1)    begin n_fail++; $display("FAIL full_ready_restored: got %b required 1", pc_ready); end
        drain();
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        drain();
        mem_lat = 3;
        tick(); pc_valid = 1'b1; pc_in = 32'h10;
        tick(); pc_in = 32'h14;
        tick(); pc_in = 32'h40; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (pc_ready !== 1'b0)       begin n_fail++; $display("FAIL flush_pc_ready: got %b required 0", pc_ready); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_req_valid: got %b required 0", imem_req_valid); end
        tick(); flush = 1'b0;
        @(negedge clk);
        n_checks++; if (dut.r_drop_cnt !== CW'(2)) begin n_fail++; $display("FAIL flush_drop_cnt: got %0d required 2", dut.r_drop_cnt); end
        n_checks++; if (instr_valid !== 1'b0)      begin n_fail++; $display("FAIL flush_next_valid: got %b required 0", instr_valid); end
        tick(); pc_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                n_checks++;
                if (instr_pc !== 32'h40) begin n_fail++; $display("FAIL flush_first_pc: got %h required 00000040", instr_pc); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL flush_timeout: got no instruction, required pc 00000040"); end
    endtask

    task automatic test_flush_collision();
        drain();
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            tick(); instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h200 + 32'(4 * i);
        end
        tick(); pc_valid = 1'b0; instr_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            n_fail++; $display("FAIL coll_setup: got valid=%b pc=%h required valid=1 pc=00000200", instr_valid, instr_pc); end
        tick(); flush = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0)       begin n_fail++; $display("FAIL coll_valid: got %b required 0", instr_valid); end
        n_checks++; if (dut.r_drop_cnt !== CW'(1))  begin n_fail++; $display("FAIL coll_drop_cnt: got %0d required 1", dut.r_drop_cnt); end
        n_checks++; if (dut.w_data_count !== CW'(0)) begin n_fail++; $display("FAIL coll_data_count: got %0d required 0", dut.w_data_count); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0)       begin n_fail++; $display("FAIL coll_valid2: got %b required 0", instr_valid); end
        n_checks++; if (dut.r_drop_cnt !== CW'(0))  begin n_fail++; $display("FAIL coll_drop_done: got %0d required 0", dut.r_drop_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        drain();
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            tick(); instr_ready = 1'b0; pc_valid = 1'b1; pc_in = 32'h300 + 32'(4 * i);
        end
        tick(); pc_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_buffered: got %b required 1", instr_valid); end
        tick(); reset = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b required 0", instr_valid); end
        n_checks++; if (pc_ready !== 1'b0)    begin n_fail++; $display("FAIL rmid_pc_ready: got %b required 0", pc_ready); end
        n_checks++; if (instr_pc !== 32'h0)   begin n_fail++; $display("FAIL rmid_pc: got %h required 0", instr_pc); end
        tick(); reset = 1'b1; mem_lat = 1; instr_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rel_valid: got %b required 0", instr_valid); end
        tick(); pc_valid = 1'b1; pc_in = 32'h100;
        tick(); pc_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                n_checks++;
                if (instr_pc !== 32'h100 || instr_data !== mem_word(32'h100)) begin
                    n_fail++; $display("FAIL rmid_fetch: got pc=%h data=%h required pc=00000100 data=%h", instr_pc, instr_data, mem_word(32'h100)); end
            end
            tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_timeout: got no instruction, required pc 00000100"); end
    endtask

    task automatic test_bypass();
        drain();
        mem_lat = 1;
        tick(); pc_valid = 1'b1; pc_in = 32'h20;
        tick(); pc_valid = 1'b0;
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr_data !== mem_word(32'h20)) begin
            n_fail++; $display("FAIL byp_same_cycle: got valid=%b pc=%h data=%h required valid=1 pc=00000020 data=%h",
                               instr_valid, instr_pc, instr_data, mem_word(32'h20)); end
        n_checks++; if (dut.w_data_count !== CW'(0)) begin n_fail++; $display("FAIL byp_count: got %0d required 0", dut.w_data_count); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b0 || dut.w_data_count !== CW'(0)) begin
            n_fail++; $display("FAIL byp_after: got valid=%b count=%0d required valid=0 count=0", instr_valid, dut.w_data_count); end
`else
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL lat_rsp_cycle: got %b required 0", instr_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin
            n_fail++; $display("FAIL lat_next_cycle: got valid=%b pc=%h required valid=1 pc=00000020", instr_valid, instr_pc); end
`endif
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
            pc_valid       = ($urandom_range(0, 3) != 0);
            pc_in          = $urandom() & 32'hFFFF_FFFC;
            instr_ready    = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 4) != 0);
            flush          = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            n_checks++;
            if (imem_addr !== pc_in) begin n_fail++; $display("FAIL rand_imem_addr: got %h required %h", imem_addr, pc_in); end
            if (flush) begin
                n_checks++;
                if (imem_req_valid !== 1'b0 || pc_ready !== 1'b0) begin
                    n_fail++; $display("FAIL rand_flush_req: got req_valid=%b pc_ready=%b required 0 and 0", imem_req_valid, pc_ready); end
            end
        end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0; pc_valid = 1'b0; pc_in = '0; flush = 1'b0;
        instr_ready = 1'b0; imem_req_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_full();
        test_flush();
        test_flush_collision();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
